muxnto1_rr: RTL
===============

# muxnto1_rr

Registered N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output. It is the parametrised successor to the team's 2:1 combinational mux: any channel count, any data width, a fixed-select mode and a round-robin arbitration mode. It sits between several producer streams and one consumer. Latency is one cycle, and it sustains one word per cycle under back-pressure.

## Interface
Parameters:
- W, 8, data width per channel (≥1)
- N, 4, channel count (≥2); SW = max(1, clog2(N)) is derived, not overridable

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = fixed select by s; 1 = round-robin arbitration
- s  in  SW  channel select, used only when mode=0
- a  in  N*W  packed channel data; channel i is a[i*W +: W]
- a_valid  in  N  per-channel valid
- a_ready  out  N  per-channel ready (combinational)
- t  out  W  registered output data
- t_ch  out  SW  index of the channel that produced t
- t_valid  out  1  output valid
- t_ready  in  1  consumer ready

## Operation
- Output register: t, t_ch, t_valid.
- load = !t_valid || t_ready. The register accepts a new word only when load is 1.
- Grant selection:
  - mode=0: grant = s if s < N and a_valid[s]; otherwise no grant. Values of s ≥ N (N not a power of 2) never grant.
  - mode=1: grant = first channel with a_valid set, scanning ptr+1, ptr+2, … with wrap modulo N. No grant if every a_valid is 0.
- a_ready[i] = load && (grant == i) && !rst. At most one bit is set, and a_ready is 0 for every non-granted channel.
- Transfer on channel i occurs when a_valid[i] && a_ready[i]. At the next edge: t ← a[i], t_ch ← i, t_valid ← 1.
- If load=1 and there is no grant: t_valid ← 0 at the next edge; t and t_ch hold.
- If load=0 (t_valid && !t_ready): t, t_ch and t_valid hold, and all a_ready are 0.
- Round-robin pointer ptr (SW bits):
  - Updates to i only on a transfer in mode=1.
  - Never changes in mode=0.
- Mode and s may change on any cycle; the new value applies to the grant in that same cycle.
- Producers must hold a[i] stable while a_valid[i]=1 and a_ready[i]=0. The block does not check this.

## Timing
- Reset (async assert, sampled release): t=0, t_ch=0, t_valid=0, ptr=N-1 (so channel 0 wins the first round-robin scan), a_ready=0.
- Reset mid-operation drops any word held in the output register. No partial state survives.
- Latency: input transfer at edge k gives t_valid=1 with the data after edge k.
- Throughput: 1 word per cycle while t_ready=1 and a grant exists.
- Simultaneous t_ready=1 and a new transfer: the output word is consumed and replaced in the same edge, with no bubble.
- Round-robin fairness: with all N channels continuously valid and t_ready=1, grants cycle 0,1,…,N-1,0,… and each channel gets exactly 1 of every N transfers.
- Pointer wrap: when ptr=N-1 the scan starts at 0.
- Back-pressure: while t_ready=0 and t_valid=1, outputs are stable bit-for-bit.
- Combinational paths: t_ready → a_ready and a_valid/s/mode → a_ready are allowed. There is no path from a_valid to t in the same cycle.

## Test plan
- Reset: assert rst mid-stream with t_valid=1 → t=0, t_ch=0, t_valid=0, a_ready=0 immediately. After release with mode=1 and all a_valid=1, the first transfer is from channel 0.
- Fixed select (W=8, N=4): mode=0, s=2, a[2]=0xA5, a_valid=4'b0100, t_ready=1 → a_ready=4'b0100; next cycle t=0xA5, t_ch=2, t_valid=1. With s=1 and only a_valid[1]=0 → no grant, t_valid falls to 0.
- Round-robin fairness: mode=1, a_valid=4'b1111, t_ready=1 for 8 cycles → t_ch sequence 0,1,2,3,0,1,2,3 and t=a[t_ch] each cycle.
- Sparse round-robin: a_valid=4'b1001, ptr=0 → grants 3,0,3,0. Also drop a_valid[3] mid-sequence → channel 0 is granted on every cycle.
- Back-pressure: t_valid=1, t_ready=0 for 5 cycles → t and t_ch are unchanged and a_ready=0. Raise t_ready with a_valid[1]=1 → consume and reload in the same edge, no bubble.
- Non-power-of-2 (N=3, SW=2): mode=0, s=3 → a_ready=0 and t_valid goes to 0. In mode=1 the wrap goes 2→0, and t_ch never equals 3.

Source files
------------

// File: rtl/muxnto1_rr.sv
`timescale 1ns/1ps
// Registered N-channel stream multiplexer with valid/ready on every port.
// Fixed-select mode (mode=0) or round-robin arbitration (mode=1); one-cycle
// latency, full throughput under back-pressure.
module muxnto1_rr #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4,
  localparam int unsigned SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  input  logic [N*W-1:0] a,
  input  logic [N-1:0]   a_valid,
  output logic [N-1:0]   a_ready,
  output logic [W-1:0]   t,
  output logic [SW-1:0]  t_ch,
  output logic           t_valid,
  input  logic           t_ready
);

  logic [SW-1:0] r_ptr;
  logic          w_load;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt;
  logic [W-1:0]  w_gnt_data;

  // Output register may take a new word when empty or being drained this cycle.
  assign w_load = !t_valid || t_ready;

  // Grant selection: fixed by s, or first valid channel after r_ptr (with wrap).
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (!mode) begin
      // s >= N matches no channel, so it never grants.
      for (int unsigned i = 0; i < N; i++) begin
        if (s == SW'(i) && a_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SW'(i);
        end
      end
    end else begin
      // Scan farthest offset first so the nearest valid channel wins last.
      for (int unsigned k = N; k >= 1; k--) begin
        idx = (32'(r_ptr) + k) % N;
        if (a_valid[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SW'(idx);
        end
      end
    end
  end

  // Data mux of the granted channel and one-hot ready back to producers.
  always_comb begin
    w_gnt_data = '0;
    a_ready    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_gnt == SW'(i)) begin
        w_gnt_data = a[i*W +: W];
      end
      a_ready[i] = w_load && w_gnt_vld && (w_gnt == SW'(i)) && !rst;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t       <= '0;
      t_ch    <= '0;
      t_valid <= 1'b0;
      r_ptr   <= SW'(N - 1);
    end else if (w_load) begin
      if (w_gnt_vld) begin
        t       <= w_gnt_data;
        t_ch    <= w_gnt;
        t_valid <= 1'b1;
        if (mode) begin
          r_ptr <= w_gnt;
        end
      end else begin
        t_valid <= 1'b0;
      end
    end
  end

endmodule
